// File: rtl/fp_mac_pkg.sv
// Shared constants, types and packing helper for the FP multiply-accumulate datapath.
// Covers field widths, the exponent bias and the bit offsets of the packed single-precision result.
package fp_mac_pkg;

  localparam int MANT_W   = 24;
  localparam int EXP_W    = 8;
  localparam int BIAS     = 127;
  localparam int EXP_MAX  = 255;
  localparam int FRAC_W   = MANT_W - 1;
  localparam int IEXP_W   = EXP_W + 2;
  localparam int PROD_W   = 2 * MANT_W;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;

  typedef logic signed [IEXP_W-1:0] iexp_t;
  typedef logic [FRAC_W-1:0]        frac_t;

  // Stage-1 payload: normalised significand plus rounding information.
  typedef struct packed {
    logic  sign;
    logic  zero;
    iexp_t exp;
    frac_t frac;
    logic  guard;
    logic  sticky;
  } norm_t;

  function automatic logic [31:0] pack_result(logic sign, logic [EXP_W-1:0] exp, frac_t frac);
    logic [31:0] r;
    r                  = '0;
    r[SIGN_BIT]        = sign;
    r[EXP_HI:EXP_LO]   = exp;
    r[FRAC_HI:0]       = frac;
    return r;
  endfunction

endpackage

// File: rtl/rne_rounder.sv
// Round-to-nearest-even on a normalised 23-bit fraction.
// A carry out of the significand renormalises to 1.0 and bumps the exponent.
module rne_rounder
  import fp_mac_pkg::*;
(
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  input  logic [IEXP_W-1:0] exp_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic [IEXP_W-1:0] exp_o
);

  logic          round_up;
  logic          carry;
  logic [FRAC_W-1:0] frac_sum;

  assign round_up = guard_i & (sticky_i | frac_i[0]);

  // Adding to {1,frac} overflows exactly when the fraction itself carries out.
  assign {carry, frac_sum} = {1'b0, frac_i} + {{FRAC_W{1'b0}}, round_up};

  always_comb begin
    frac_o = frac_sum;
    exp_o  = exp_i;
    if (carry) begin
      frac_o = '0;
      exp_o  = exp_i + IEXP_W'(1);
    end
  end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Two-stage normalise / round-and-pack pipeline behind the FP multiplier mantissa product.
// Stage 1 normalises the 48-bit product; stage 2 rounds to nearest-even and packs an IEEE single.
module fp_mul_norm_round
  import fp_mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow
);

  logic        s1_valid_q, s1_valid_d;
  norm_t       s1_q, s1_d, norm_in;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic        out_overflow_q, out_overflow_d;
  logic        out_underflow_q, out_underflow_d;

  logic        s1_adv;
  logic        s2_accept;
  frac_t       rnd_frac;
  iexp_t       rnd_exp;
  logic [31:0] res_n;
  logic        ov_n;
  logic        un_n;

  assign s2_accept = !out_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_accept;
  assign in_ready  = s1_adv;

  // Stage 1: pick the leading one (bit 47 or 46) and split off guard/sticky.
  always_comb begin
    norm_in      = '0;
    norm_in.sign = in_sign;
    norm_in.zero = in_zero;
    if (in_mant[47]) begin
      norm_in.frac   = in_mant[46:24];
      norm_in.guard  = in_mant[23];
      norm_in.sticky = |in_mant[22:0];
      norm_in.exp    = $signed(in_exp) + IEXP_W'(1);
    end else begin
      norm_in.frac   = in_mant[45:23];
      norm_in.guard  = in_mant[22];
      norm_in.sticky = |in_mant[21:0];
      norm_in.exp    = $signed(in_exp);
    end
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_d       = s1_adv ? norm_in  : s1_q;
  end

  rne_rounder u_rne_rounder (
    .frac_i   (s1_q.frac),
    .guard_i  (s1_q.guard),
    .sticky_i (s1_q.sticky),
    .exp_i    (s1_q.exp),
    .frac_o   (rnd_frac),
    .exp_o    (rnd_exp)
  );

  // Stage 2: exponent range checks in priority order; bubbles load an all-zero result.
  always_comb begin
    res_n = '0;
    ov_n  = 1'b0;
    un_n  = 1'b0;
    if (s1_q.zero) begin
      res_n = pack_result(s1_q.sign, '0, '0);
    end else if (rnd_exp >= iexp_t'(EXP_MAX)) begin
      res_n = pack_result(s1_q.sign, 8'hFF, '0);
      ov_n  = 1'b1;
    end else if (rnd_exp <= iexp_t'(0)) begin
      res_n = pack_result(s1_q.sign, '0, '0);
      un_n  = 1'b1;
    end else begin
      res_n = pack_result(s1_q.sign, rnd_exp[EXP_W-1:0], rnd_frac);
    end
    if (!s1_valid_q) begin
      res_n = '0;
      ov_n  = 1'b0;
      un_n  = 1'b0;
    end
    out_valid_d     = s2_accept ? s1_valid_q : out_valid_q;
    out_result_d    = s2_accept ? res_n      : out_result_q;
    out_overflow_d  = s2_accept ? ov_n       : out_overflow_q;
    out_underflow_d = s2_accept ? un_n       : out_underflow_q;
  end

  // NOTE: the stage-1 payload is not reset; it is only observed behind s1_valid_q.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    if (rst) begin
      s1_valid_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_overflow_q  <= 1'b0;
      out_underflow_q <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_overflow_q  <= out_overflow_d;
      out_underflow_q <= out_underflow_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_overflow  = out_overflow_q;
  assign out_underflow = out_underflow_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Scoreboard bench for fp_mul_norm_round: a reference model predicts each beat at input
// transfer; results are popped and compared at output transfer, with stall-stability checks.
module tb_fp_mul_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        un;
  } res_t;

  res_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;
  int   cyc      = 0;
  int   ready_mode = 0;   // 0: always ready, 1: stall window cycles 2-5, 2: random, 3: hold
  logic acc;
  logic saw_in_ready_low;
  logic hold_valid = 1'b0;
  res_t hold_val;

  always #5 clk = ~clk;

  fp_mul_norm_round dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .in_zero       (in_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask

  // Reference: locate the leading one, shift, then round on the exact remainder.
  function automatic res_t model(logic s, logic [9:0] e10, logic [47:0] m, logic z);
    res_t r;
    logic [47:0] sig, rem, half;
    int sh, e;
    e   = int'($signed(e10));
    sh  = m[47] ? 24 : 23;
    e   = e + (m[47] ? 1 : 0);
    sig = m >> sh;
    rem = m & ((48'd1 << sh) - 48'd1);
    half = 48'd1 << (sh - 1);
    if (rem > half || (rem == half && sig[0])) sig = sig + 48'd1;
    if (sig[24]) begin
      sig = sig >> 1;
      e++;
    end
    r = '0;
    if (z)             r.res = {s, 31'b0};
    else if (e >= 255) begin r.res = {s, 8'hFF, 23'b0}; r.ov = 1'b1; end
    else if (e <= 0)   begin r.res = {s, 31'b0};        r.un = 1'b1; end
    else               r.res = {s, e[7:0], sig[22:0]};
    return r;
  endfunction

  // One clock: monitor at the falling edge, drive just after the rising edge.
  task automatic tick();
    res_t e;
    @(negedge clk);
    acc = 1'b0;
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'({out_result, out_overflow, out_underflow}), 64'(hold_val));
      end
      if (in_valid && !in_ready) saw_in_ready_low = 1'b1;
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("result", 64'(out_result), 64'(e.res));
          check("overflow", 64'(out_overflow), 64'(e.ov));
          check("underflow", 64'(out_underflow), 64'(e.un));
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        sb_q.push_back(model(in_sign, in_exp, in_mant, in_zero));
      end
      hold_valid = out_valid && !out_ready;
      hold_val   = '{res: out_result, ov: out_overflow, un: out_underflow};
    end
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = !(cyc >= 2 && cyc <= 5);
      2: out_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  endtask

  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m, input logic z);
    int n;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_zero  = z;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < 100);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int n0;
    logic [47:0] m;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; in_zero = 1'b0;
    out_ready = 1'b1;
    saw_in_ready_low = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_flags", 64'({out_overflow, out_underflow}), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Two-cycle latency on an isolated beat.
    send(1'b0, 10'd127, 48'h400000000000, 1'b0);
    in_valid = 1'b0;
    check("latency_c1", 64'(out_valid), 64'd0);
    tick();
    check("latency_c2", 64'(out_valid), 64'd1);
    drain();

    // Directed vectors, back to back.
    send(1'b0, 10'd127, 48'h900000000000, 1'b0);
    send(1'b0, 10'd127, 48'h400000C00000, 1'b0);
    send(1'b0, 10'd127, 48'h400000400000, 1'b0);
    send(1'b1, 10'd254, 48'h800000000000, 1'b0);
    send(1'b0, 10'd0,   48'h400000000000, 1'b0);
    send(1'b0, 10'd254, 48'h7FFFFFFFFFFF, 1'b0);
    send(1'b1, 10'd77,  48'h000000000000, 1'b1);
    drain();

    // Backpressure: four beats with out_ready low for cycles 2-5.
    n0 = n_out;
    saw_in_ready_low = 1'b0;
    cyc = 0;
    ready_mode = 1;
    for (int i = 0; i < 4; i++)
      send(i[0], 10'(120 + i), {2'b01, 46'(i * 48'h123456789)}, 1'b0);
    drain();
    check("bp_in_ready_dropped", 64'(saw_in_ready_low), 64'd1);
    check("bp_count", 64'(n_out - n0), 64'd4);

    // Random traffic with random backpressure and gaps.
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      m = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        m[47] = 1'b0;
        m[46] = 1'b1;
      end else begin
        m[47] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) m[21:0] = '0;
      send($urandom_range(0, 1) == 1, 10'($signed($urandom_range(0, 400)) - 130),
           m, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    drain();

    // Reset with two beats in flight: both are discarded.
    ready_mode = 3;
    out_ready = 1'b0;
    send(1'b0, 10'd127, 48'h400000000000, 1'b0);
    send(1'b1, 10'd128, 48'h900000000000, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    sb_q.delete();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    ready_mode = 0;
    repeat (4) tick();
    send(1'b1, 10'd50, 48'h0, 1'b1);
    drain();
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_mul_norm_round.md
Name: fp_mul_norm_round

Overview:
Downstream stage of the FP multiplier mantissa adder. Takes the 48-bit unsigned mantissa product, the pre-biased exponent sum and the sign. Normalises, rounds to nearest-even and packs an IEEE-754 single-precision result for the MAC accumulator. Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
MANT_W, 24, significand width including hidden bit; product width is 2*MANT_W
EXP_W, 8, IEEE exponent field width; internal signed exponent is EXP_W+2 bits
BIAS, 127, exponent bias

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  input beat valid
in_ready  output  1  stage can accept a beat
in_sign  input  1  product sign (sign_a ^ sign_b)
in_exp  input  10  two's-complement biased exponent, exp_a+exp_b-BIAS
in_mant  input  48  raw mantissa product, 1.xx*1.xx, so bit47 or bit46 is set unless zero
in_zero  input  1  either operand is zero
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  32  packed {sign, exp[7:0], frac[22:0]}
out_overflow  output  1  result saturated to infinity
out_underflow  output  1  result flushed to zero

Behaviour:
- Decided interface: single clock clk; rst is synchronous and active-high.
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_overflow=0, out_underflow=0. in_ready=1 from the first cycle after reset.
- Handshake: a beat transfers when valid&&ready on the same edge.
  - s2 accepts when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 accepts.
  - in_ready = !s1_valid || s2 accepts (combinational). Full throughput; no bubbles under continuous out_ready.
- Latency: 2 cycles from input transfer to out_valid with no stall.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Stage 1, normalise, registered:
  - bit47=1: frac=mant[46:24], guard=mant[23], sticky=|mant[22:0], exp=in_exp+1.
  - Otherwise: frac=mant[45:23], guard=mant[22], sticky=|mant[21:0], exp=in_exp.
  - Carry sign and zero.
- Stage 2, round and pack, registered:
  - round_up = guard & (sticky | frac[0]).
  - Add round_up to {1,frac}. On carry-out, frac=0 and exp+=1.
- Final exponent checks, in priority order:
  - zero flag: result {sign, 31'b0}, flags 0.
  - exp >= 255: result {sign, 8'hFF, 23'b0}, out_overflow=1.
  - exp <= 0, signed compare: result {sign, 31'b0}, out_underflow=1. No denormals.
  - Otherwise: {sign, exp[7:0], frac}.
- Flags are qualified by out_valid and valid only for the current beat.
- Simultaneous s2 drain and s1 load in one cycle is legal; no beat is lost or duplicated.
- rst asserted mid-operation discards both pipeline beats. out_valid=0 on the next edge.
- NaN/Inf inputs are out of scope; upstream flags them separately.

Decomposition:
- Shared package fp_mac_pkg: BIAS, EXP_MAX=255, MANT_W, EXP_W, and the packed-result field offsets (sign 31, exp 30:23, frac 22:0).
- One sub-module, rne_rounder: combinational; inputs frac, guard, sticky, exp; outputs rounded frac and exp. Instantiated in stage 2.
- Stage registers and handshake logic stay in the top module.

Test Plan:
- 1.0*1.0: in_mant=48'h400000000000, in_exp=127, sign 0 -> two cycles later out_result=32'h3F800000, flags 0.
- 1.5*1.5: in_mant=48'h900000000000, in_exp=127 -> 32'h40100000 (2.25).
- Tie to odd: in_mant=48'h400000C00000, in_exp=127 -> 32'h3F800002. Tie to even: in_mant=48'h400000400000 -> 32'h3F800000.
- Overflow: in_mant=48'h800000000000, in_exp=254, sign 1 -> 32'hFF800000, out_overflow=1. Underflow: in_mant=48'h400000000000, in_exp=0 -> 32'h00000000, out_underflow=1.
- Backpressure: stream 4 beats with out_ready=0 for cycles 2-5.
  - in_ready drops once both stages are full.
  - Outputs held stable while stalled.
  - All 4 results appear in order, no loss.
- Reset mid-flight: 2 beats in the pipe, assert rst for 1 cycle -> out_valid=0 next cycle, no stale result emitted; in_zero beat afterward -> {sign, 31'b0}.
